// File: rtl/range_pkg.sv
// Shared types for the range-finder frame sequencer.
package range_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_t;

endpackage

// File: rtl/sample_fifo.sv
// Sample buffer: power-of-2 circular FIFO with a combinational head read and synchronous clear.
module sample_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  // Pointers wrap naturally because DEPTH is a power of 2; clear beats push/pop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push && !clear) r_mem[r_wr_ptr] <= wdata;
  end

  assign rdata = r_mem[r_rd_ptr];
  assign count = r_count;

endmodule

// File: rtl/range_frame_sequencer.sv
// Buffers a sample stream and replays it as gap-free go..finish frames to the
// range finder, capturing the returned range/error on each finish cycle.
module range_frame_sequencer
  import range_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned FRAME_LEN = 8,
  parameter int unsigned DEPTH     = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] rf_data,
  output logic             rf_go,
  output logic             rf_finish,
  input  logic [WIDTH-1:0] rf_range,
  input  logic             rf_error,
  output logic [WIDTH-1:0] result,
  output logic             result_error,
  output logic             result_valid
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned FW = $clog2(FRAME_LEN);

  seq_state_t       r_state;
  seq_state_t       w_next_state;
  logic [FW-1:0]    r_frame_cnt;
  logic [FW-1:0]    w_frame_cnt_nxt;
  logic             r_flush_pend;
  logic             w_flush_pend_nxt;
  logic [CW-1:0]    w_count;
  logic [WIDTH-1:0] w_head;
  logic             w_push;
  logic             w_pop;
  logic             w_clear;
  logic             w_capture;

  sample_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .clear (w_clear),
    .wdata (in_data),
    .rdata (w_head),
    .count (w_count)
  );

  assign in_ready = (w_count < CW'(DEPTH));
  assign w_push   = in_valid && in_ready && !w_clear;

  // State, frame position and deferred-flush flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_frame_cnt  <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_frame_cnt  <= w_frame_cnt_nxt;
      r_flush_pend <= w_flush_pend_nxt;
    end
  end

  // A flush arriving on the go cycle is deferred like one arriving mid-frame.
  always_comb begin
    w_next_state     = r_state;
    w_frame_cnt_nxt  = r_frame_cnt;
    w_flush_pend_nxt = r_flush_pend;
    w_pop            = 1'b0;
    w_clear          = 1'b0;
    w_capture        = 1'b0;
    rf_go            = 1'b0;
    rf_finish        = 1'b0;
    rf_data          = '0;
    if (r_state == IDLE) begin
      if (r_flush_pend) begin
        w_clear          = 1'b1;
        w_flush_pend_nxt = 1'b0;
      end else if (w_count >= CW'(FRAME_LEN)) begin
        rf_go           = 1'b1;
        rf_data         = w_head;
        w_pop           = 1'b1;
        w_frame_cnt_nxt = FW'(1);
        w_next_state    = RUN;
        if (flush) w_flush_pend_nxt = 1'b1;
      end else if (flush) begin
        w_clear = 1'b1;
      end
    end else begin
      rf_data         = w_head;
      w_pop           = 1'b1;
      w_frame_cnt_nxt = r_frame_cnt + FW'(1);
      if (flush) w_flush_pend_nxt = 1'b1;
      if (r_frame_cnt == FW'(FRAME_LEN - 1)) begin
        rf_finish       = 1'b1;
        w_capture       = 1'b1;
        w_frame_cnt_nxt = '0;
        w_next_state    = IDLE;
      end
    end
  end

  // Range finder response is sampled on the finish cycle and flagged one cycle later.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      result       <= '0;
      result_error <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= w_capture;
      if (w_capture) begin
        result       <= rf_range;
        result_error <= rf_error;
      end
    end
  end

endmodule

// File: tb/tb_range_frame_sequencer.sv
// Self-checking bench: queue-based frame model checked every cycle, plus directed literal checks.
module tb_range_frame_sequencer;

  localparam int FL = 4;
  localparam int DP = 8;
  localparam int W  = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          flush = 1'b0;
  logic [W-1:0]  rf_data;
  logic          rf_go;
  logic          rf_finish;
  logic [W-1:0]  rf_range;
  logic          rf_error = 1'b0;
  logic [W-1:0]  result;
  logic          result_error;
  logic          result_valid;

  range_frame_sequencer #(
    .WIDTH     (W),
    .FRAME_LEN (FL),
    .DEPTH     (DP)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .flush        (flush),
    .rf_data      (rf_data),
    .rf_go        (rf_go),
    .rf_finish    (rf_finish),
    .rf_range     (rf_range),
    .rf_error     (rf_error),
    .result       (result),
    .result_error (result_error),
    .result_valid (result_valid)
  );

  always #5 clock = ~clock;

  // Behavioural range finder: max minus min of the samples seen since go.
  logic [W-1:0] rng_max = '0, rng_min = '0, cur_max, cur_min;
  always_comb begin
    if (rf_go) begin
      cur_max = rf_data;
      cur_min = rf_data;
    end else begin
      cur_max = (rf_data > rng_max) ? rf_data : rng_max;
      cur_min = (rf_data < rng_min) ? rf_data : rng_min;
    end
    rf_range = cur_max - cur_min;
  end
  always @(posedge clock) begin
    rng_max <= cur_max;
    rng_min <= cur_min;
  end

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Model state: buffered samples, position in frame (-1 = between frames), pending flush, result.
  int q[$];
  int pos = -1;
  bit pend = 1'b0;
  int m_result = 0;
  int m_range = 0;
  bit m_err = 1'b0;
  bit m_rv = 1'b0;
  int cyc = 0;
  int go_cnt = 0, fin_cnt = 0, rv_cnt = 0;
  int last_fin_cyc = -100;
  int last_gap = -1;

  always @(negedge clock) begin
    bit exp_ready, exp_go, exp_fin, do_pop, do_clear, cap;
    int exp_data, mx, mn;
    cyc++;
    if (rf_go) begin
      go_cnt++;
      last_gap = cyc - last_fin_cyc;
    end
    if (rf_finish) begin
      fin_cnt++;
      last_fin_cyc = cyc;
    end
    if (result_valid) rv_cnt++;

    if (!reset) begin
      q.delete();
      pos = -1; pend = 1'b0; m_result = 0; m_err = 1'b0; m_rv = 1'b0;
      check("rst_go", 32'(rf_go), 0);
      check("rst_finish", 32'(rf_finish), 0);
      check("rst_data", 32'(rf_data), 0);
      check("rst_ready", 32'(in_ready), 1);
      check("rst_rvalid", 32'(result_valid), 0);
      check("rst_result", 32'(result), 0);
      check("rst_rerr", 32'(result_error), 0);
    end else begin
      exp_ready = (q.size() < DP);
      exp_go = 0; exp_fin = 0; exp_data = 0; do_pop = 0; do_clear = 0; cap = 0;
      if (pos < 0) begin
        if (pend) begin
          do_clear = 1; pend = 0;
        end else if (q.size() >= FL) begin
          exp_go = 1; exp_data = q[0]; do_pop = 1; pos = 1;
          mx = q[0]; mn = q[0];
          for (int i = 1; i < FL; i++) begin
            if (q[i] > mx) mx = q[i];
            if (q[i] < mn) mn = q[i];
          end
          m_range = mx - mn;
          if (flush) pend = 1;
        end else if (flush) begin
          do_clear = 1;
        end
      end else begin
        exp_data = q[0]; do_pop = 1;
        if (flush) pend = 1;
        if (pos == FL - 1) begin
          exp_fin = 1; cap = 1; pos = -1;
        end else begin
          pos++;
        end
      end
      check("in_ready", 32'(in_ready), 32'(exp_ready));
      check("rf_go", 32'(rf_go), 32'(exp_go));
      check("rf_finish", 32'(rf_finish), 32'(exp_fin));
      check("rf_data", 32'(rf_data), 32'(exp_data));
      check("result_valid", 32'(result_valid), 32'(m_rv));
      check("result", 32'(result), 32'(m_result));
      check("result_error", 32'(result_error), 32'(m_err));
      m_rv = cap;
      if (cap) begin
        m_result = m_range;
        m_err = rf_error;
      end
      if (do_clear) q.delete();
      else begin
        if (do_pop) void'(q.pop_front());
        if (in_valid && exp_ready) q.push_back(int'(in_data));
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push(input int v);
    int budget;
    budget = 50;
    in_data  = W'(v);
    in_valid = 1'b1;
    while (!in_ready && budget > 0) begin
      tick();
      budget--;
    end
    check("push_ready_wait", 32'(in_ready), 1);
    tick();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    flush    = 1'b0;
    tick(n);
  endtask

  task automatic flush_idle();
    in_valid = 1'b0;
    flush    = 1'b1;
    tick();
    flush    = 1'b0;
  endtask

  int go0, fin0, rv0;

  initial begin
    tick(3);
    reset = 1'b1;
    check("post_rst_ready", 32'(in_ready), 1);
    check("post_rst_go", 32'(rf_go), 0);
    check("post_rst_count", 32'(dut.w_count), 0);

    // 1: single frame 3,9,1,7 -> range 8
    go0 = go_cnt; rv0 = rv_cnt;
    push(3); push(9); push(1); push(7);
    in_valid = 1'b0;
    check("t1_go_now", 32'(rf_go), 1);
    check("t1_go_data", 32'(rf_data), 3);
    tick(3);
    check("t1_finish", 32'(rf_finish), 1);
    check("t1_fin_data", 32'(rf_data), 7);
    idle(4);
    check("t1_result", 32'(result), 8);
    check("t1_rerr", 32'(result_error), 0);
    check("t1_rv_pulses", 32'(rv_cnt - rv0), 1);
    check("t1_go_count", 32'(go_cnt - go0), 1);

    // 2: partial frame never starts
    go0 = go_cnt;
    push(11); push(12); push(13);
    idle(20);
    check("t2_no_go", 32'(go_cnt - go0), 0);
    check("t2_ready", 32'(in_ready), 1);
    check("t2_count", 32'(dut.w_count), 3);
    flush_idle();
    check("t2_flush_count", 32'(dut.w_count), 0);

    // 3: continuous stream, order preserved by model
    go0 = go_cnt;
    for (int i = 0; i < 20; i++) push(100 + i);
    idle(8);
    check("t3_frames", 32'(go_cnt - go0), 5);
    check("t3_count", 32'(dut.w_count), 0);

    // 4: ten samples -> two back-to-back frames, two left over
    go0 = go_cnt; fin0 = fin_cnt;
    rf_error = 1'b1;
    push(5); push(50); push(7); push(12);
    push(30); push(2); push(8); push(40);
    push(1); push(1);
    idle(6);
    check("t4_frames", 32'(go_cnt - go0), 2);
    check("t4_finishes", 32'(fin_cnt - fin0), 2);
    check("t4_gap", 32'(last_gap), 1);
    check("t4_result", 32'(result), 38);
    check("t4_rerr", 32'(result_error), 1);
    check("t4_leftover", 32'(dut.w_count), 2);
    rf_error = 1'b0;
    flush_idle();
    check("t4_cleared", 32'(dut.w_count), 0);

    // 5: flush on second frame cycle with six samples pushed
    go0 = go_cnt; rv0 = rv_cnt;
    push(21); push(22); push(23); push(24); push(25);
    in_data = W'(26);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle(4);
    check("t5_count", 32'(dut.w_count), 0);
    check("t5_rv", 32'(rv_cnt - rv0), 1);
    idle(10);
    check("t5_no_more_go", 32'(go_cnt - go0), 1);
    check("t5_result", 32'(result), 3);

    // 6: reset on the third frame cycle
    rv0 = rv_cnt;
    push(10); push(20); push(30); push(40);
    in_valid = 1'b0;
    tick(2);
    reset = 1'b0;
    #1;
    check("t6_go", 32'(rf_go), 0);
    check("t6_finish", 32'(rf_finish), 0);
    check("t6_data", 32'(rf_data), 0);
    tick(3);
    reset = 1'b1;
    idle(2);
    check("t6_no_rv", 32'(rv_cnt - rv0), 0);
    push(4); push(4); push(4); push(4);
    idle(6);
    check("t6_rv", 32'(rv_cnt - rv0), 1);
    check("t6_result", 32'(result), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
